// File: rtl/pipe_stage_buffer_if.sv
// rtl/pipe_stage_buffer_if.sv - upstream/downstream handshake bundle for pipe_stage_buffer
interface pipe_stage_buffer_if #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 136
);
  logic              ValidIn;
  logic              ReadyIn;
  logic [CTRL_W-1:0] CtrlIn;
  logic [DATA_W-1:0] DataIn;
  logic              ValidOut;
  logic              ReadyOut;
  logic [CTRL_W-1:0] CtrlOut;
  logic [DATA_W-1:0] DataOut;

  // Buffer side: consumes the upstream entry, presents the head downstream.
  modport slave (
    input  ValidIn, CtrlIn, DataIn, ReadyOut,
    output ReadyIn, ValidOut, CtrlOut, DataOut
  );

  // Environment side: drives upstream entry and downstream ready.
  modport master (
    output ValidIn, CtrlIn, DataIn, ReadyOut,
    input  ReadyIn, ValidOut, CtrlOut, DataOut
  );
endinterface

// File: rtl/pipe_stage_buffer.sv
// rtl/pipe_stage_buffer.sv - inter-stage pipeline register with 2-entry skid buffer and flush
module pipe_stage_buffer #(
  parameter int                CTRL_W    = 16,
  parameter int                DATA_W    = 136,
  parameter logic [CTRL_W-1:0] KILL_MASK = 16'h003F,
  parameter int                CNT_W     = 8
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  input  logic                 FlushE,
  pipe_stage_buffer_if.slave   bus,
  output logic [1:0]           Occupancy,
  output logic [CNT_W-1:0]     KillCount
);

  // Main entry M drives the outputs; skid entry S catches the one extra
  // transfer that arrives while ReadyIn is still registered high.
  logic              m_v, s_v;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl;
  logic [DATA_W-1:0] m_data, s_data;
  logic              ready_q;
  logic [CNT_W-1:0]  kill_q;

  logic              m_v_n, s_v_n;
  logic [CTRL_W-1:0] m_ctrl_n, s_ctrl_n;
  logic [DATA_W-1:0] m_data_n, s_data_n;
  logic [CNT_W-1:0]  kill_n;
  logic [CNT_W+1:0]  kill_sum;

  logic accept, pop;

  assign accept = bus.ValidIn & ready_q;
  assign pop    = m_v & bus.ReadyOut;

  // Next-state: normal M/S movement, or valid-clear and kill counting on flush.
  always_comb begin
    m_v_n    = m_v;
    s_v_n    = s_v;
    m_ctrl_n = m_ctrl;
    s_ctrl_n = s_ctrl;
    m_data_n = m_data;
    s_data_n = s_data;
    kill_n   = kill_q;
    kill_sum = '0;
    if (FlushE) begin
      // Payload registers hold; only the valid bits drop. A head popped
      // this cycle was delivered, so it is not counted as killed.
      m_v_n    = 1'b0;
      s_v_n    = 1'b0;
      kill_sum = {2'b00, kill_q}
               + {{(CNT_W+1){1'b0}}, m_v & ~pop}
               + {{(CNT_W+1){1'b0}}, s_v}
               + {{(CNT_W+1){1'b0}}, accept};
      if (kill_sum > {2'b00, {CNT_W{1'b1}}})
        kill_n = {CNT_W{1'b1}};
      else
        kill_n = kill_sum[CNT_W-1:0];
    end else if (pop && s_v) begin
      m_v_n    = 1'b1;
      m_ctrl_n = s_ctrl;
      m_data_n = s_data;
      s_v_n    = 1'b0;
      if (accept) begin
        s_v_n    = 1'b1;
        s_ctrl_n = bus.CtrlIn;
        s_data_n = bus.DataIn;
      end
    end else if (pop || !m_v) begin
      m_v_n = accept;
      if (accept) begin
        m_ctrl_n = bus.CtrlIn;
        m_data_n = bus.DataIn;
      end
    end else if (accept) begin
      s_v_n    = 1'b1;
      s_ctrl_n = bus.CtrlIn;
      s_data_n = bus.DataIn;
    end
  end

  // State register; reset outranks flush and drops entries uncounted.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      m_v     <= 1'b0;
      s_v     <= 1'b0;
      m_ctrl  <= '0;
      s_ctrl  <= '0;
      m_data  <= '0;
      s_data  <= '0;
      ready_q <= 1'b0;
      kill_q  <= '0;
    end else begin
      m_v     <= m_v_n;
      s_v     <= s_v_n;
      m_ctrl  <= m_ctrl_n;
      s_ctrl  <= s_ctrl_n;
      m_data  <= m_data_n;
      s_data  <= s_data_n;
      ready_q <= ~s_v_n;
      kill_q  <= kill_n;
    end
  end

  assign bus.ReadyIn  = ready_q;
  assign bus.ValidOut = m_v;
  assign bus.CtrlOut  = m_ctrl & ~(KILL_MASK & {CTRL_W{~m_v}});
  assign bus.DataOut  = m_data;
  assign Occupancy    = {1'b0, m_v} + {1'b0, s_v};
  assign KillCount    = kill_q;

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// tb/tb_pipe_stage_buffer.sv - directed vector bench for pipe_stage_buffer
module tb_pipe_stage_buffer;

  logic         CLK;
  logic         rstn, flush, vin, rdy;
  logic [15:0]  ctrl_in;
  logic [135:0] data_in;
  logic [1:0]   occ_a, occ_b;
  logic [7:0]   kill_a;
  logic [1:0]   kill_b;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_buffer_if #(.CTRL_W(16), .DATA_W(136)) bus_a ();
  pipe_stage_buffer_if #(.CTRL_W(16), .DATA_W(136)) bus_b ();

  assign bus_a.ValidIn  = vin;
  assign bus_a.CtrlIn   = ctrl_in;
  assign bus_a.DataIn   = data_in;
  assign bus_a.ReadyOut = rdy;
  assign bus_b.ValidIn  = vin;
  assign bus_b.CtrlIn   = ctrl_in;
  assign bus_b.DataIn   = data_in;
  assign bus_b.ReadyOut = rdy;

  pipe_stage_buffer #(.CTRL_W(16), .DATA_W(136), .KILL_MASK(16'h003F), .CNT_W(8)) dut_a (
    .CLK(CLK), .RESETn(rstn), .FlushE(flush), .bus(bus_a),
    .Occupancy(occ_a), .KillCount(kill_a)
  );

  pipe_stage_buffer #(.CTRL_W(16), .DATA_W(136), .KILL_MASK(16'h003F), .CNT_W(2)) dut_b (
    .CLK(CLK), .RESETn(rstn), .FlushE(flush), .bus(bus_b),
    .Occupancy(occ_b), .KillCount(kill_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic         rstn, flush, vin, rdy;
    logic [15:0]  ctrl_in;
    logic [135:0] data_in;
    logic         e_vout;
    logic [15:0]  e_ctrl;
    logic [135:0] e_data;
    logic         e_rdyin;
    logic [1:0]   e_occ;
    logic [7:0]   e_kill;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic f, logic v, logic ro, logic [135:0] d,
                              logic ev, logic [15:0] ec, logic [135:0] ed,
                              logic er, logic [1:0] eo, logic [7:0] ek);
    vec_t t;
    t.rstn = r; t.flush = f; t.vin = v; t.rdy = ro;
    t.ctrl_in = 16'hFFFF; t.data_in = d;
    t.e_vout = ev; t.e_ctrl = ec; t.e_data = ed;
    t.e_rdyin = er; t.e_occ = eo; t.e_kill = ek;
    return t;
  endfunction

  task automatic check(string name, logic [135:0] act, logic [135:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(logic r, logic f, logic v, logic ro, logic [15:0] c, logic [135:0] d);
    rstn = r; flush = f; vin = v; rdy = ro; ctrl_in = c; data_in = d;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, '0);

    //             rstn flush vin rdy data    vout ctrlout   data  rdyin occ kill
    // reset, then stream 1,2,3
    vecs.push_back(mk(0, 0, 0, 1, 0,        0, 16'h0000, 0,     0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0,        0, 16'h0000, 0,     0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 1,        0, 16'h0000, 0,     1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 1,        1, 16'hFFFF, 1,     1, 1, 0));
    vecs.push_back(mk(1, 0, 1, 1, 2,        1, 16'hFFFF, 2,     1, 1, 0));
    vecs.push_back(mk(1, 0, 1, 1, 3,        1, 16'hFFFF, 3,     1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 3,        0, 16'hFFC0, 3,     1, 0, 0));
    // backpressure: 5 in M, 6 in S, 7 held upstream, then drain in order
    vecs.push_back(mk(1, 0, 1, 0, 5,        1, 16'hFFFF, 5,     1, 1, 0));
    vecs.push_back(mk(1, 0, 1, 0, 6,        1, 16'hFFFF, 5,     0, 2, 0));
    vecs.push_back(mk(1, 0, 1, 0, 7,        1, 16'hFFFF, 5,     0, 2, 0));
    vecs.push_back(mk(1, 0, 1, 1, 7,        1, 16'hFFFF, 6,     1, 1, 0));
    vecs.push_back(mk(1, 0, 1, 1, 7,        1, 16'hFFFF, 7,     1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 7,        0, 16'hFFC0, 7,     1, 0, 0));
    // flush with one held entry plus an accept: two killed
    vecs.push_back(mk(1, 0, 1, 0, 8,        1, 16'hFFFF, 8,     1, 1, 0));
    vecs.push_back(mk(1, 1, 1, 0, 9,        0, 16'hFFC0, 8,     1, 0, 2));
    // flush during pop: 9 is delivered, not counted
    vecs.push_back(mk(1, 0, 1, 0, 9,        1, 16'hFFFF, 9,     1, 1, 2));
    vecs.push_back(mk(1, 1, 0, 1, 9,        0, 16'hFFC0, 9,     1, 0, 2));
    // reset outranks flush with the buffer full
    vecs.push_back(mk(1, 0, 1, 0, 10,       1, 16'hFFFF, 10,    1, 1, 2));
    vecs.push_back(mk(1, 0, 1, 0, 11,       1, 16'hFFFF, 10,    0, 2, 2));
    vecs.push_back(mk(0, 1, 1, 0, 11,       0, 16'h0000, 0,     0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,        0, 16'h0000, 0,     1, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].rstn, vecs[i].flush, vecs[i].vin, vecs[i].rdy,
            vecs[i].ctrl_in, vecs[i].data_in);
      tick();
      check($sformatf("v%0d ValidOut", i),  136'(bus_a.ValidOut), 136'(vecs[i].e_vout));
      check($sformatf("v%0d CtrlOut", i),   136'(bus_a.CtrlOut),  136'(vecs[i].e_ctrl));
      check($sformatf("v%0d DataOut", i),   bus_a.DataOut,        vecs[i].e_data);
      check($sformatf("v%0d ReadyIn", i),   136'(bus_a.ReadyIn),  136'(vecs[i].e_rdyin));
      check($sformatf("v%0d Occupancy", i), 136'(occ_a),          136'(vecs[i].e_occ));
      check($sformatf("v%0d KillCount", i), 136'(kill_a),         136'(vecs[i].e_kill));
    end

    // Saturation on the CNT_W=2 instance, plus non-masked ctrl bits passing through.
    drive(1, 0, 1, 0, 16'hA5C3, 136'h1);
    tick();
    check("sat load CtrlOut", 136'(bus_b.CtrlOut), 136'(16'hA5C3));
    drive(1, 0, 1, 0, 16'hA5C3, 136'h2);
    tick();
    check("sat full occ", 136'(occ_b), 136'(2'd2));
    drive(1, 1, 0, 0, 16'hA5C3, 136'h2);
    tick();
    check("sat flush1 kill_b", 136'(kill_b), 136'(2'd2));
    check("sat flush1 kill_a", 136'(kill_a), 136'(8'd2));
    check("sat flush1 CtrlOut masked", 136'(bus_b.CtrlOut), 136'(16'hA5C0));
    check("sat flush1 ValidOut", 136'(bus_b.ValidOut), 136'(1'b0));
    drive(1, 0, 1, 0, 16'hA5C3, 136'h3);
    tick();
    drive(1, 0, 1, 0, 16'hA5C3, 136'h4);
    tick();
    check("sat refill occ", 136'(occ_b), 136'(2'd2));
    drive(1, 1, 0, 0, 16'hA5C3, 136'h4);
    tick();
    check("sat flush2 kill_b", 136'(kill_b), 136'(2'd3));
    check("sat flush2 kill_a", 136'(kill_a), 136'(8'd4));
    drive(1, 1, 1, 0, 16'hA5C3, 136'h5);
    tick();
    check("sat flush3 kill_b", 136'(kill_b), 136'(2'd3));
    check("sat flush3 kill_a", 136'(kill_a), 136'(8'd5));
    check("sat flush3 occ", 136'(occ_b), 136'(2'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
